// File: rtl/ternary_dual_issue_sched.sv
// ternary_dual_issue_sched
//   Issue scheduler for the dual-issue ternary pipeline. Sits between decode
//   and the EX-stage registers of slots A and B. It decides each cycle whether
//   the decoded pair issues together, issues split (A now, B in a later
//   cycle), or stalls.
//
//   Register addresses are three trits. Each trit is 2 bits:
//   00 = T_ZERO, 01 = T_POS, 10 = T_NEG. Register R0 is all T_ZERO and is
//   never a hazard source or destination.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   flush                    kill the presented decode pair (branch redirect)
//   dec_valid / dec_ready    decode pair handshake (pair held until dec_ready)
//   dec_b_valid              slot B carries a real instruction
//   a_* / b_*                slot register addresses and attributes
//   issue_a, issue_b         slot enters EX this cycle
//   stall                    decode held, nothing issued
//   split                    pair is being issued over two cycles
//
// Optional build macro TERNARY_ISSUE_PERF_EN adds CNT_W-bit saturating
// counters perf_dual, perf_split and perf_stall.
module ternary_dual_issue_sched #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic            dec_b_valid,
    input  logic [2:0][1:0] a_rs1,
    input  logic [2:0][1:0] a_rs2,
    input  logic [2:0][1:0] a_rd,
    input  logic            a_reg_write,
    input  logic            a_is_load,
    input  logic            a_is_mem,
    input  logic            a_is_branch,
    input  logic [2:0][1:0] b_rs1,
    input  logic [2:0][1:0] b_rs2,
    input  logic [2:0][1:0] b_rd,
    input  logic            b_reg_write,
    input  logic            b_is_load,
    input  logic            b_is_mem,
    output logic            issue_a,
    output logic            issue_b,
    output logic            stall,
    output logic            split
`ifdef TERNARY_ISSUE_PERF_EN
    ,
    output logic [CNT_W-1:0] perf_dual,
    output logic [CNT_W-1:0] perf_split,
    output logic [CNT_W-1:0] perf_stall
`endif
);

    typedef logic [2:0][1:0] reg_t;
    typedef enum logic {RUN, HOLD_B} state_t;

    if (LOAD_LAT < 1 || LOAD_LAT > 3) begin : g_bad_lat
        $error("LOAD_LAT must be 1..3");
    end
    if (CNT_W < 1) begin : g_bad_cnt
        $error("CNT_W must be at least 1");
    end

    state_t     state, state_nxt;
    reg_t       sba_rd, sbb_rd;
    logic [1:0] sba_cnt, sbb_cnt;

    logic ia, ib, rdy, stl, spl;
    logic haz_a, haz_b, split_b;

    // A source is pending if it is not R0 and matches any live load entry.
    function automatic logic pend(input reg_t s, input reg_t r0, input logic [1:0] c0,
                                  input reg_t r1, input logic [1:0] c1);
        return (s != '0) && (((s == r0) && (c0 != 2'd0)) || ((s == r1) && (c1 != 2'd0)));
    endfunction

    assign haz_a = pend(a_rs1, sba_rd, sba_cnt, sbb_rd, sbb_cnt)
                 | pend(a_rs2, sba_rd, sba_cnt, sbb_rd, sbb_cnt);
    assign haz_b = pend(b_rs1, sba_rd, sba_cnt, sbb_rd, sbb_cnt)
                 | pend(b_rs2, sba_rd, sba_cnt, sbb_rd, sbb_cnt);

    // Cases the same-cycle EX_A -> B forwarding path cannot cover.
    assign split_b = (a_is_load && a_reg_write && (a_rd != '0) &&
                      ((b_rs1 == a_rd) || (b_rs2 == a_rd)))
                   || (a_is_mem && b_is_mem)
                   || a_is_branch
                   || haz_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ia  = 1'b0;
        ib  = 1'b0;
        rdy = 1'b0;
        stl = 1'b0;
        spl = 1'b0;
        case (state)
            RUN: begin
                if (flush) begin
                    rdy = 1'b1;
                end else if (dec_valid) begin
                    if (haz_a) begin
                        stl = 1'b1;
                    end else if (dec_b_valid && split_b) begin
                        ia        = 1'b1;
                        spl       = 1'b1;
                        state_nxt = HOLD_B;
                    end else begin
                        ia  = 1'b1;
                        ib  = dec_b_valid;
                        rdy = 1'b1;
                    end
                end
            end
            HOLD_B: begin
                // A already went; only B's scoreboard hazards remain. A's
                // own result reaches B through MEM_A/WB_A forwarding.
                if (flush) begin
                    rdy       = 1'b1;
                    state_nxt = RUN;
                end else if (haz_b) begin
                    stl = 1'b1;
                    spl = 1'b1;
                end else begin
                    ib        = 1'b1;
                    spl       = 1'b1;
                    rdy       = 1'b1;
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    assign issue_a   = ia  & ~rst;
    assign issue_b   = ib  & ~rst;
    assign dec_ready = rdy & ~rst;
    assign stall     = stl & ~rst;
    assign split     = spl & ~rst;

    // Load scoreboard: an issuing slot overwrites its entry (live only for
    // loads that write a register); an idle slot's entry counts down.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sba_rd  <= '0;
            sba_cnt <= 2'd0;
            sbb_rd  <= '0;
            sbb_cnt <= 2'd0;
        end else begin
            if (issue_a) begin
                sba_rd  <= a_rd;
                sba_cnt <= (a_is_load && a_reg_write) ? 2'(LOAD_LAT) : 2'd0;
            end else if (sba_cnt != 2'd0) begin
                sba_cnt <= sba_cnt - 2'd1;
            end
            if (issue_b) begin
                sbb_rd  <= b_rd;
                sbb_cnt <= (b_is_load && b_reg_write) ? 2'(LOAD_LAT) : 2'd0;
            end else if (sbb_cnt != 2'd0) begin
                sbb_cnt <= sbb_cnt - 2'd1;
            end
        end
    end

`ifdef TERNARY_ISSUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_dual  <= '0;
            perf_split <= '0;
            perf_stall <= '0;
        end else begin
            if (issue_a && issue_b && !(&perf_dual))
                perf_dual <= perf_dual + 1'b1;
            if (state == RUN && state_nxt == HOLD_B && !(&perf_split))
                perf_split <= perf_split + 1'b1;
            if (stall && !(&perf_stall))
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ternary_dual_issue_sched.sv
module tb_ternary_dual_issue_sched;
    localparam int LAT = 2;

    localparam logic [5:0] R0 = 6'b000000;
    localparam logic [5:0] R1 = 6'b000001;
    localparam logic [5:0] R2 = 6'b000010;
    localparam logic [5:0] R3 = 6'b000100;
    localparam logic [5:0] R4 = 6'b001000;
    localparam logic [5:0] R5 = 6'b000101;
    localparam logic [5:0] R6 = 6'b001001;

    typedef struct packed {
        logic [5:0] rs1, rs2, rd;
        logic       rw, ld, mem, br;
    } ins_t;

    typedef struct {
        logic       fl, dv, bv;
        ins_t       a, b;
        logic [4:0] exp;   // {issue_a, issue_b, dec_ready, stall, split}
    } vec_t;

    logic       clk = 1'b0, rst = 1'b1, flush = 1'b0, dec_valid = 1'b0, dec_b_valid = 1'b0;
    logic       dec_ready, issue_a, issue_b, stall, split;
    logic [5:0] a_rs1 = '0, a_rs2 = '0, a_rd = '0, b_rs1 = '0, b_rs2 = '0, b_rd = '0;
    logic       a_reg_write = 1'b0, a_is_load = 1'b0, a_is_mem = 1'b0, a_is_branch = 1'b0;
    logic       b_reg_write = 1'b0, b_is_load = 1'b0, b_is_mem = 1'b0;
`ifdef TERNARY_ISSUE_PERF_EN
    logic [3:0] perf_dual, perf_split, perf_stall;
`endif

    int   n_chk = 0, n_pass = 0;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ternary_dual_issue_sched #(.LOAD_LAT(LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_b_valid(dec_b_valid),
        .a_rs1(a_rs1), .a_rs2(a_rs2), .a_rd(a_rd), .a_reg_write(a_reg_write),
        .a_is_load(a_is_load), .a_is_mem(a_is_mem), .a_is_branch(a_is_branch),
        .b_rs1(b_rs1), .b_rs2(b_rs2), .b_rd(b_rd), .b_reg_write(b_reg_write),
        .b_is_load(b_is_load), .b_is_mem(b_is_mem),
        .issue_a(issue_a), .issue_b(issue_b), .stall(stall), .split(split)
`ifdef TERNARY_ISSUE_PERF_EN
        , .perf_dual(perf_dual), .perf_split(perf_split), .perf_stall(perf_stall)
`endif
    );

    function automatic ins_t alu(input logic [5:0] rd, input logic [5:0] s1, input logic [5:0] s2);
        return '{rs1: s1, rs2: s2, rd: rd, rw: 1'b1, ld: 1'b0, mem: 1'b0, br: 1'b0};
    endfunction
    function automatic ins_t ld(input logic [5:0] rd, input logic [5:0] s1);
        return '{rs1: s1, rs2: R0, rd: rd, rw: 1'b1, ld: 1'b1, mem: 1'b1, br: 1'b0};
    endfunction
    function automatic ins_t st(input logic [5:0] s1, input logic [5:0] s2);
        return '{rs1: s1, rs2: s2, rd: R0, rw: 1'b0, ld: 1'b0, mem: 1'b1, br: 1'b0};
    endfunction
    function automatic ins_t br(input logic [5:0] s1, input logic [5:0] s2);
        return '{rs1: s1, rs2: s2, rd: R0, rw: 1'b0, ld: 1'b0, mem: 1'b0, br: 1'b1};
    endfunction

    task automatic add(input logic fl, input logic dv, input logic bv,
                       input ins_t a, input ins_t b, input logic [4:0] exp);
        vec_t v;
        v.fl = fl; v.dv = dv; v.bv = bv; v.a = a; v.b = b; v.exp = exp;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic drive(input vec_t v);
        flush = v.fl; dec_valid = v.dv; dec_b_valid = v.bv;
        a_rs1 = v.a.rs1; a_rs2 = v.a.rs2; a_rd = v.a.rd;
        a_reg_write = v.a.rw; a_is_load = v.a.ld; a_is_mem = v.a.mem; a_is_branch = v.a.br;
        b_rs1 = v.b.rs1; b_rs2 = v.b.rs2; b_rd = v.b.rd;
        b_reg_write = v.b.rw; b_is_load = v.b.ld; b_is_mem = v.b.mem;
    endtask

    function automatic int outs();
        return int'({issue_a, issue_b, dec_ready, stall, split});
    endfunction

    // Drive at the negedge, check mid-low phase, advance to the next negedge.
    task automatic step(input vec_t v, input string nm);
        drive(v);
        #2;
        chk(nm, outs(), int'(v.exp));
        @(negedge clk);
    endtask

    initial begin
        ins_t nop;
        vec_t v;
        nop = '0;

        // Cycle-by-cycle sequence from reset, LOAD_LAT = 2.
        add(0,0,0, nop,               nop,               5'b00000); // 0 idle
        add(0,1,1, alu(R1,R0,R0),     alu(R2,R1,R0),     5'b11100); // 1 dual via EX_A fwd
        add(0,1,1, ld(R3,R0),         alu(R4,R3,R0),     5'b10001); // 2 load-to-B split
        add(0,1,1, ld(R3,R0),         alu(R4,R3,R0),     5'b00011); // 3 B waits on load
        add(0,1,1, ld(R3,R0),         alu(R4,R3,R0),     5'b00011); // 4
        add(0,1,1, ld(R3,R0),         alu(R4,R3,R0),     5'b01101); // 5 B issues
        add(0,1,1, st(R1,R2),         ld(R5,R0),         5'b10001); // 6 mem port conflict
        add(0,1,1, st(R1,R2),         ld(R5,R0),         5'b01101); // 7
        add(0,1,0, alu(R6,R5,R0),     nop,               5'b00010); // 8 load-use on B entry
        add(0,1,0, alu(R6,R5,R0),     nop,               5'b00010); // 9
        add(0,1,0, alu(R6,R5,R0),     nop,               5'b10100); // 10
        add(0,1,0, ld(R5,R0),         nop,               5'b10100); // 11
        add(0,1,1, alu(R6,R0,R0),     alu(R4,R0,R1),     5'b11100); // 12 R0 read, R5 pending
        add(0,1,1, br(R1,R2),         alu(R2,R0,R0),     5'b10001); // 13 branch in A
        add(1,1,1, br(R1,R2),         alu(R2,R0,R0),     5'b00100); // 14 flush in HOLD_B
        add(0,1,1, alu(R1,R0,R0),     alu(R2,R0,R0),     5'b11100); // 15 back in RUN
        add(0,1,0, ld(R3,R0),         nop,               5'b10100); // 16
        add(1,1,0, alu(R4,R3,R0),     nop,               5'b00100); // 17 flush beats hazard
        add(0,1,0, alu(R4,R3,R0),     nop,               5'b00010); // 18 load still pending
        add(0,1,0, alu(R4,R3,R0),     nop,               5'b10100); // 19
        add(0,1,1, alu(R5,R0,R0),     ld(R4,R0),         5'b11100); // 20 load in B, dual
        add(0,1,0, alu(R6,R0,R4),     nop,               5'b00010); // 21 rs2 hazard
        add(0,1,0, alu(R6,R0,R4),     nop,               5'b00010); // 22
        add(0,1,0, alu(R6,R0,R4),     nop,               5'b10100); // 23
        add(0,1,1, ld(R0,R1),         alu(R2,R0,R0),     5'b11100); // 24 load to R0: no split
        add(0,1,0, alu(R1,R0,R0),     nop,               5'b10100); // 25 R0 entry harmless
        add(0,1,1, ld(R3,R1),         alu(R4,R0,R3),     5'b10001); // 26 B rs2 == load rd
        add(0,1,1, ld(R3,R1),         alu(R4,R0,R3),     5'b00011); // 27
        add(0,1,1, ld(R3,R1),         alu(R4,R0,R3),     5'b00011); // 28
        add(0,1,1, ld(R3,R1),         alu(R4,R0,R3),     5'b01101); // 29

        // Reset state: a valid pair is presented while rst is high.
        drive(tbl[1]);
        #2;
        chk("reset_outputs", outs(), 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));

        // Mid-HOLD_B reset drops the held B and returns to RUN.
        v = tbl[13];
        step(v, "hold_enter");
        drive(v);
        rst = 1'b1;
        #2;
        chk("rst_in_hold", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        step(v, "run_after_rst");          // re-splits, so state was RUN
        v.exp = 5'b01101;
        step(v, "hold_issue_b");

`ifdef TERNARY_ISSUE_PERF_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("perf_dual_rst", int'(perf_dual), 0);
        chk("perf_split_rst", int'(perf_split), 0);
        chk("perf_stall_rst", int'(perf_stall), 0);
        for (int k = 0; k < 20; k++) step(tbl[15], "perf_pair");
        chk("perf_dual_sat", int'(perf_dual), 15);
        step(tbl[16], "perf_ld");
        v = tbl[18];
        step(v, "perf_stall1");
        step(v, "perf_stall2");
        v.exp = 5'b10100;
        step(v, "perf_go");
        chk("perf_stall_cnt", int'(perf_stall), 2);
        step(tbl[13], "perf_split_in");
        chk("perf_split_cnt", int'(perf_split), 1);
        chk("perf_dual_hold", int'(perf_dual), 15);
        rst = 1'b1;
        #2;
        chk("perf_rst_outs", outs(), 0);
        chk("perf_dual_clr", int'(perf_dual), 0);
        chk("perf_split_clr", int'(perf_split), 0);
        chk("perf_stall_clr", int'(perf_stall), 0);
        @(negedge clk);
        rst = 1'b0;
        step(tbl[13], "perf_run_after");
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
